// File: rtl/dmem_pkg.sv
// Shared definitions for the data-port responder: MMIO register map,
// bad-read pattern and the address decoder.
package dmem_pkg;

    // MMIO register byte offsets within the 32-byte window
    localparam logic [4:0] CONSOLE  = 5'h00;
    localparam logic [4:0] STATUS   = 5'h04;
    localparam logic [4:0] CYCLE_LO = 5'h08;
    localparam logic [4:0] CYCLE_HI = 5'h0C;
    localparam logic [4:0] HALT     = 5'h10;

    localparam logic [31:0] MMIO_BYTES = 32'd32;
    localparam logic [31:0] BAD_READ   = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_t;

    // Offsets are computed modulo 2^32 so a base near the top of the
    // address space still decodes correctly with a single compare.
    function automatic region_t decode(input logic [31:0] addr,
                                       input logic [31:0] ram_base,
                                       input logic [31:0] ram_bytes,
                                       input logic [31:0] mmio_base);
        logic [31:0] ram_off;
        logic [31:0] mmio_off;
        ram_off  = addr - ram_base;
        mmio_off = addr - mmio_base;
        if (ram_off < ram_bytes) begin
            return REG_RAM;
        end else if (mmio_off < MMIO_BYTES) begin
            return REG_MMIO;
        end
        return REG_NONE;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core data-port bus: address, byte-lane write enables, write and read data.
interface dmem_responder_if;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wr_data;
    logic [31:0] d_rd_data;

    modport master (
        output d_addr,
        output d_we,
        output d_wr_data,
        input  d_rd_data
    );

    modport slave (
        input  d_addr,
        input  d_we,
        input  d_wr_data,
        output d_rd_data
    );
endinterface

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with occupancy count. A push while full is
// accepted only when a pop happens in the same cycle.
module byte_fifo #(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [7:0]       wr_data,
    output logic             full,
    input  logic             pop,
    output logic [7:0]       rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Storage is not reset, so mask the head while empty to keep tx_data at 0
    assign rd_data = empty ? 8'h00 : mem[rd_ptr_q];

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: byte-lane RAM plus an MMIO window holding the
// console FIFO, a free-running 64-bit cycle counter and the halt register.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 4096,
    parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dmem_responder_if.slave        bus,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   halt,
    output logic [7:0]             exit_code,
    output logic                   err
);

    localparam int unsigned IDX_W     = $clog2(RAM_WORDS);
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

    logic [31:0]      ram [RAM_WORDS];
    region_t          region;
    logic [IDX_W-1:0] ram_idx;
    logic [4:0]       mmio_reg;
    logic             any_we;
    logic             console_push;
    logic             halt_wr;
    logic             bad_wr;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       drop_q;
    logic [63:0]      cycle_q;
    logic             halt_q;
    logic [7:0]       exit_q;
    logic             err_q;
    logic [31:0]      status;

    assign region   = decode(bus.d_addr, RAM_BASE, RAM_BYTES, MMIO_BASE);
    assign ram_idx  = IDX_W'((bus.d_addr - RAM_BASE) >> 2);
    assign mmio_reg = 5'(bus.d_addr - MMIO_BASE) & 5'h1C;
    assign any_we   = |bus.d_we;

    assign console_push = (region == REG_MMIO) && (mmio_reg == CONSOLE) && bus.d_we[0];
    assign halt_wr      = (region == REG_MMIO) && (mmio_reg == HALT) && any_we;
    assign bad_wr       = (region == REG_NONE) && any_we;
    assign fifo_pop     = tx_valid && tx_ready;

    assign tx_valid  = !fifo_empty;
    assign halt      = halt_q;
    assign exit_code = exit_q;
    assign err       = err_q;

    assign status = {16'h0, drop_q, 6'h0, fifo_count == CNT_W'(FIFO_DEPTH), fifo_count == '0};

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (console_push),
        .wr_data (bus.d_wr_data[7:0]),
        .full    (fifo_full),
        .pop     (fifo_pop),
        .rd_data (tx_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // RAM byte-lane writes; contents survive reset but writes during reset are dropped
    always_ff @(posedge clk) begin
        if (rst_n && region == REG_RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.d_we[i]) begin
                    ram[ram_idx][8*i +: 8] <= bus.d_wr_data[8*i +: 8];
                end
            end
        end
    end

    // Console drop counter: a push is lost only when full with no pop alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'h00;
        end else if (console_push && fifo_full && !fifo_pop && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'h01;
        end
    end

    // Free-running cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= 64'h0;
        end else begin
            cycle_q <= cycle_q + 64'h1;
        end
    end

    // Sticky halt/err flags; each HALT write replaces the exit code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
            exit_q <= 8'h00;
            err_q  <= 1'b0;
        end else begin
            if (halt_wr) begin
                halt_q <= 1'b1;
                exit_q <= bus.d_wr_data[7:0];
            end
            if (bad_wr) begin
                err_q <= 1'b1;
            end
        end
    end

    // Combinational read mux
    always_comb begin
        bus.d_rd_data = BAD_READ;
        unique case (region)
            REG_RAM: bus.d_rd_data = ram[ram_idx];
            REG_MMIO: begin
                case (mmio_reg)
                    STATUS:   bus.d_rd_data = status;
                    CYCLE_LO: bus.d_rd_data = cycle_q[31:0];
                    CYCLE_HI: bus.d_rd_data = cycle_q[63:32];
                    HALT:     bus.d_rd_data = {31'h0, halt_q};
                    default:  bus.d_rd_data = 32'h0;
                endcase
            end
            default: bus.d_rd_data = BAD_READ;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written multi-cycle
// sequences and a randomized phase, all checked against a behavioural model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam logic [31:0] MMIO    = 32'h1000_0000;
    localparam logic [31:0] RAM_TOP = 32'h0000_4000;
    localparam int          DEPTH   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       halt;
    logic [7:0] exit_code;
    logic       err;

    dmem_responder_if bus ();

    dmem_responder #(
        .RAM_WORDS  (4096),
        .RAM_BASE   (32'h0000_0000),
        .MMIO_BASE  (MMIO),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .halt      (halt),
        .exit_code (exit_code),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] mem_m [int];
    logic [7:0]  q_m [$];
    int          drop_m;
    logic        halt_m;
    logic [7:0]  exit_m;
    logic        err_m;
    logic [63:0] cyc_m;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wd;
        logic        rdy;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        q_m.delete();
        drop_m = 0;
        halt_m = 1'b0;
        exit_m = 8'h00;
        err_m  = 1'b0;
        cyc_m  = 64'h0;
    endfunction

    // Returns 1 when the model knows what a read of 'a' must return
    function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
        logic [31:0] off;
        off = a - MMIO;
        v = 32'h0;
        if (a < RAM_TOP) begin
            if (!mem_m.exists(int'(a >> 2))) return 1'b0;
            v = mem_m[int'(a >> 2)];
        end else if (off < 32) begin
            case (off & 32'h1C)
                32'h04: v = {16'h0, 8'(drop_m), 6'h0, q_m.size() == DEPTH, q_m.size() == 0};
                32'h08: v = cyc_m[31:0];
                32'h0C: v = cyc_m[63:32];
                32'h10: v = {31'h0, halt_m};
                default: v = 32'h0;
            endcase
        end else begin
            v = 32'hDEAD_BEEF;
        end
        return 1'b1;
    endfunction

    function automatic void model_clock(input logic [31:0] a, input logic [3:0] we,
                                        input logic [31:0] wd, input logic rdy);
        logic [31:0] off;
        logic [31:0] old;
        bit          in_ram;
        bit          in_mmio;
        bit          pop;
        bit          push;
        int          pre;
        off     = a - MMIO;
        in_ram  = a < RAM_TOP;
        in_mmio = off < 32;
        pre     = q_m.size();
        pop     = (pre != 0) && rdy;
        push    = in_mmio && ((off & 32'h1C) == 0) && we[0];
        if (we != 4'h0) begin
            if (in_ram) begin
                // Partial writes to a never-written word leave it unknown
                if (mem_m.exists(int'(a >> 2)) || we == 4'hF) begin
                    old = mem_m.exists(int'(a >> 2)) ? mem_m[int'(a >> 2)] : 32'h0;
                    for (int i = 0; i < 4; i++)
                        if (we[i]) old[8*i +: 8] = wd[8*i +: 8];
                    mem_m[int'(a >> 2)] = old;
                end
            end else if (in_mmio) begin
                if ((off & 32'h1C) == 32'h10) begin
                    halt_m = 1'b1;
                    exit_m = wd[7:0];
                end
            end else begin
                err_m = 1'b1;
            end
        end
        if (pop) void'(q_m.pop_front());
        if (push) begin
            if (pre < DEPTH || pop) q_m.push_back(wd[7:0]);
            else if (drop_m < 255) drop_m++;
        end
        cyc_m = cyc_m + 64'h1;
    endfunction

    // One bus cycle: entered and left at a negedge
    task automatic apply(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                         input logic rdy, input bit chk, input logic [31:0] exp,
                         input string tag);
        logic [31:0] v;
        bus.d_addr    = a;
        bus.d_we      = we;
        bus.d_wr_data = wd;
        tx_ready      = rdy;
        #2;
        if (model_read(a, v)) check({tag, " rd_data/model"}, bus.d_rd_data, v);
        if (chk) check({tag, " rd_data"}, bus.d_rd_data, exp);
        check({tag, " tx_valid"}, tx_valid, q_m.size() != 0);
        check({tag, " tx_data"}, tx_data, (q_m.size() != 0) ? q_m[0] : 8'h00);
        check({tag, " halt"}, halt, halt_m);
        check({tag, " exit_code"}, exit_code, exit_m);
        check({tag, " err"}, err, err_m);
        @(posedge clk);
        model_clock(a, we, wd, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.d_we = 4'h0;
        tx_ready = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  we;

        bus.d_addr    = 32'h0;
        bus.d_we      = 4'h0;
        bus.d_wr_data = 32'h0;
        model_clear();
        @(negedge clk);
        #2;
        check("reset tx_valid", tx_valid, 1'b0);
        check("reset tx_data", tx_data, 8'h00);
        bus.d_addr = MMIO + 32'h4;
        #1;
        check("reset STATUS", bus.d_rd_data, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        tbl.push_back('{32'h100, 4'hF, 32'hAABB_CCDD, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{32'h100, 4'h1, 32'h0000_0011, 1'b0, 1'b1, 32'hAABB_CCDD});
        tbl.push_back('{32'h100, 4'h0, 32'h0, 1'b0, 1'b1, 32'hAABB_CC11});
        tbl.push_back('{MMIO, 4'h1, 32'h48, 1'b0, 1'b1, 32'h0});
        tbl.push_back('{MMIO, 4'h1, 32'h69, 1'b0, 1'b1, 32'h0});
        tbl.push_back('{MMIO + 32'h4, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0});
        tbl.push_back('{MMIO + 32'h4, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0});
        tbl.push_back('{MMIO + 32'h4, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0});
        tbl.push_back('{MMIO + 32'h4, 4'h0, 32'h0, 1'b1, 1'b1, 32'h1});
        tbl.push_back('{MMIO + 32'h14, 4'hF, 32'h1234_5678, 1'b0, 1'b1, 32'h0});
        tbl.push_back('{MMIO + 32'h18, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0});
        tbl.push_back('{MMIO, 4'h2, 32'h55, 1'b0, 1'b1, 32'h0});
        tbl.push_back('{MMIO + 32'h4, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1});
        tbl.push_back('{MMIO + 32'h10, 4'h4, 32'h2A, 1'b0, 1'b1, 32'h0});
        tbl.push_back('{MMIO + 32'h10, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1});
        tbl.push_back('{32'h2000_0000, 4'hF, 32'h1, 1'b0, 1'b1, 32'hDEAD_BEEF});
        tbl.push_back('{32'h2000_0000, 4'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF});
        tbl.push_back('{MMIO + 32'h13, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1});
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].addr, tbl[i].we, tbl[i].wd, tbl[i].rdy, tbl[i].chk, tbl[i].exp,
                  $sformatf("vec%0d", i));
        end
        check("halt set", halt, 1'b1);
        check("exit_code", exit_code, 8'h2A);
        check("err set", err, 1'b1);

        // Cycle counter and 32-bit carry
        do_reset();
        for (int i = 0; i < 100; i++) apply(32'h100, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, "idle");
        apply(MMIO + 32'h8, 4'h0, 32'h0, 1'b0, 1'b1, 32'd100, "cycle_lo 100");
        apply(MMIO + 32'hC, 4'h0, 32'h0, 1'b0, 1'b1, 32'd0, "cycle_hi 0");
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycle_q;
        cyc_m = 64'h0000_0000_FFFF_FFFF;
        apply(MMIO + 32'h8, 4'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, "cycle_lo max");
        apply(MMIO + 32'h8, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0, "cycle_lo wrap");
        apply(MMIO + 32'hC, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1, "cycle_hi carry");

        // Overflow, in-order drain, push-while-full with pop
        do_reset();
        for (int i = 0; i < 10; i++) apply(MMIO, 4'h1, 32'h30 + i, 1'b0, 1'b1, 32'h0, "fill");
        apply(MMIO + 32'h4, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0202, "status overflow");
        for (int i = 0; i < 8; i++) begin
            check("drain order", tx_data, 8'h30 + 8'(i));
            apply(MMIO + 32'h4, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0, "drain");
        end
        apply(MMIO + 32'h4, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0201, "status drained");
        for (int i = 0; i < 8; i++) apply(MMIO, 4'h1, 32'h40 + i, 1'b0, 1'b0, 32'h0, "refill");
        apply(MMIO, 4'h1, 32'h77, 1'b1, 1'b0, 32'h0, "push+pop full");
        apply(MMIO + 32'h4, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_0202, "status no drop");

        // Async reset mid-drain
        do_reset();
        apply(MMIO + 32'h10, 4'h1, 32'h5, 1'b0, 1'b0, 32'h0, "halt pre");
        apply(32'h3000_0000, 4'h1, 32'h0, 1'b0, 1'b0, 32'h0, "err pre");
        for (int i = 0; i < 5; i++) apply(MMIO, 4'h1, 32'h61 + i, 1'b0, 1'b0, 32'h0, "q5");
        apply(MMIO + 32'h4, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0, "mid drain");
        bus.d_addr = MMIO + 32'h4;
        tx_ready   = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst tx_valid", tx_valid, 1'b0);
        check("rst tx_data", tx_data, 8'h00);
        check("rst STATUS", bus.d_rd_data, 32'h1);
        check("rst halt", halt, 1'b0);
        check("rst exit_code", exit_code, 8'h00);
        check("rst err", err, 1'b0);
        bus.d_addr    = MMIO + 32'h10;
        bus.d_we      = 4'hF;
        bus.d_wr_data = 32'h99;
        @(posedge clk);
        @(negedge clk);
        check("write in reset", halt, 1'b0);
        bus.d_we = 4'h0;
        rst_n    = 1'b1;
        model_clear();
        apply(32'h100, 4'h0, 32'h0, 1'b0, 1'b1, 32'hAABB_CC11, "ram kept");
        apply(MMIO + 32'h8, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1, "cycle after rst");

        // Randomized phase
        for (int i = 0; i < 16; i++)
            apply(32'h100 + 32'(4 * i), 4'hF, $urandom, 1'b0, 1'b0, 32'h0, "ram init");
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 32'h100 + 32'($urandom_range(0, 63));
                4, 5, 6, 7: a = MMIO + 32'($urandom_range(0, 31));
                8:          a = 32'h2000_0000 + 32'($urandom_range(0, 255));
                default:    a = RAM_TOP + 32'($urandom_range(0, 255));
            endcase
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            apply(a, we, $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'h0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
